// File: rtl/wb_write_sequencer.sv
// Writeback sequencer feeding the 32x32 register file: one result per handshake,
// LDD split into an even/odd register write pair, %g0 writes suppressed.
module wb_write_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_le,
    input  logic             in_dbl,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_data,
    input  logic [31:0]      in_data_hi,
    output logic [31:0]      PW,
    output logic [4:0]       RW,
    output logic             LE,
    output logic             busy,
    output logic [CNT_W-1:0] wr_count
);

    typedef enum logic {
        ST_IDLE,
        ST_SECOND
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pw_q, pw_d;
    logic [4:0]       rw_q, rw_d;
    logic             le_q, le_d;
    logic [31:0]      hi_q, hi_d;
    logic             le2_q, le2_d;
    logic [3:0]       rdh_q, rdh_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        state_d = state_q;
        pw_d    = pw_q;
        rw_d    = rw_q;
        le_d    = 1'b0;
        hi_d    = hi_q;
        le2_d   = le2_q;
        rdh_d   = rdh_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    pw_d = in_data;
                    if (in_dbl) begin
                        // Odd rd is forced even; only the even half can hit %g0.
                        rw_d    = {in_rd[4:1], 1'b0};
                        le_d    = in_le & (in_rd[4:1] != 4'd0);
                        hi_d    = in_data_hi;
                        le2_d   = in_le;
                        rdh_d   = in_rd[4:1];
                        state_d = ST_SECOND;
                    end else begin
                        rw_d = in_rd;
                        le_d = in_le & (in_rd != 5'd0);
                    end
                end
            end
            ST_SECOND: begin
                pw_d    = hi_q;
                rw_d    = {rdh_q, 1'b1};
                le_d    = le2_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            pw_q    <= '0;
            rw_q    <= '0;
            le_q    <= 1'b0;
            hi_q    <= '0;
            le2_q   <= 1'b0;
            rdh_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pw_q    <= pw_d;
            rw_q    <= rw_d;
            le_q    <= le_d;
            hi_q    <= hi_d;
            le2_q   <= le2_d;
            rdh_q   <= rdh_d;
            if (le_d && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_ready = (state_q == ST_IDLE) && !Rst;
    assign busy     = (state_q == ST_SECOND);
    assign PW       = pw_q;
    assign RW       = rw_q;
    assign LE       = le_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Directed vector bench for wb_write_sequencer with a behavioural register file
// on the write port and a narrow-counter instance for saturation.
module tb_wb_write_sequencer;

    logic        Clk;
    logic        Rst, in_valid, in_le, in_dbl;
    logic [4:0]  in_rd;
    logic [31:0] in_data, in_data_hi;
    logic        in_ready, LE, busy;
    logic [31:0] PW;
    logic [4:0]  RW;
    logic [15:0] wr_count;

    logic        s_rst, s_valid, s_le, s_dbl;
    logic [4:0]  s_rd;
    logic [31:0] s_data, s_hi;
    logic        s_ready, s_le_o, s_busy;
    logic [31:0] s_pw;
    logic [4:0]  s_rw;
    logic [1:0]  s_cnt;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    logic [31:0] rf [32];

    wb_write_sequencer #(.CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_le(in_le), .in_dbl(in_dbl), .in_rd(in_rd), .in_data(in_data),
        .in_data_hi(in_data_hi), .PW(PW), .RW(RW), .LE(LE), .busy(busy),
        .wr_count(wr_count)
    );

    wb_write_sequencer #(.CNT_W(2)) dut_sat (
        .Clk(Clk), .Rst(s_rst), .in_valid(s_valid), .in_ready(s_ready),
        .in_le(s_le), .in_dbl(s_dbl), .in_rd(s_rd), .in_data(s_data),
        .in_data_hi(s_hi), .PW(s_pw), .RW(s_rw), .LE(s_le_o), .busy(s_busy),
        .wr_count(s_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register file behaviour: commit PW into RW at the edge while LE is high.
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(posedge Clk) if (LE) rf[RW] <= PW;

    typedef struct {
        logic        rst, valid, le, dbl;
        logic [4:0]  rd;
        logic [31:0] data, hi;
        logic [31:0] e_pw;
        logic [4:0]  e_rw;
        logic        e_le, e_rdy, e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rst, logic valid, logic le, logic dbl,
                                logic [4:0] rd, logic [31:0] data, logic [31:0] hi,
                                logic [31:0] e_pw, logic [4:0] e_rw, logic e_le,
                                logic e_rdy, logic e_busy, logic [15:0] e_cnt);
        vec_t v;
        v.rst = rst; v.valid = valid; v.le = le; v.dbl = dbl;
        v.rd = rd; v.data = data; v.hi = hi;
        v.e_pw = e_pw; v.e_rw = e_rw; v.e_le = e_le;
        v.e_rdy = e_rdy; v.e_busy = e_busy; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    initial begin
        Rst = 1'b1; in_valid = 1'b0; in_le = 1'b0; in_dbl = 1'b0;
        in_rd = '0; in_data = '0; in_data_hi = '0;
        s_rst = 1'b1; s_valid = 1'b0; s_le = 1'b0; s_dbl = 1'b0;
        s_rd = '0; s_data = '0; s_hi = '0;

        //               rst v  le db rd  data          hi            e_pw          e_rw le rdy bsy cnt
        vq.push_back(mk(1, 0, 0, 0, 0,  32'h0,        32'h0,        32'h0,        0,  0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,  32'h0,        32'h0,        32'h0,        0,  0, 1, 0, 0));
        vq.push_back(mk(0, 1, 1, 0, 5,  32'h14,       32'h0,        32'h14,       5,  1, 1, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0,  32'h0,        32'h0,        32'h14,       5,  0, 1, 0, 1));
        vq.push_back(mk(0, 1, 1, 0, 0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0,  0, 1, 0, 1));
        vq.push_back(mk(0, 1, 1, 1, 9,  32'h11111111, 32'h22222222, 32'h11111111, 8,  1, 0, 1, 2));
        // Inputs presented during the second cycle must be ignored.
        vq.push_back(mk(0, 1, 1, 0, 3,  32'h00000BAD, 32'h0,        32'h22222222, 9,  1, 1, 0, 3));
        vq.push_back(mk(0, 1, 1, 0, 1,  32'hA1,       32'h0,        32'hA1,       1,  1, 1, 0, 4));
        vq.push_back(mk(0, 1, 1, 0, 2,  32'hA2,       32'h0,        32'hA2,       2,  1, 1, 0, 5));
        vq.push_back(mk(0, 1, 1, 0, 3,  32'hA3,       32'h0,        32'hA3,       3,  1, 1, 0, 6));
        vq.push_back(mk(0, 1, 1, 0, 4,  32'hA4,       32'h0,        32'hA4,       4,  1, 1, 0, 7));
        vq.push_back(mk(0, 0, 0, 0, 0,  32'h0,        32'h0,        32'hA4,       4,  0, 1, 0, 7));
        vq.push_back(mk(0, 1, 1, 1, 0,  32'h55,       32'hABCD0001, 32'h55,       0,  0, 0, 1, 7));
        vq.push_back(mk(0, 0, 0, 0, 0,  32'h0,        32'h0,        32'hABCD0001, 1,  1, 1, 0, 8));
        vq.push_back(mk(0, 1, 0, 1, 11, 32'h77,       32'h88,       32'h77,       10, 0, 0, 1, 8));
        vq.push_back(mk(0, 0, 0, 0, 0,  32'h0,        32'h0,        32'h88,       11, 0, 1, 0, 8));
        vq.push_back(mk(0, 1, 0, 0, 12, 32'h99,       32'h0,        32'h99,       12, 0, 1, 0, 8));
        vq.push_back(mk(0, 1, 1, 1, 6,  32'h66,       32'h67,       32'h66,       6,  1, 0, 1, 9));
        vq.push_back(mk(1, 0, 0, 0, 0,  32'h0,        32'h0,        32'h0,        0,  0, 0, 0, 0));
        vq.push_back(mk(1, 1, 1, 0, 13, 32'h1,        32'h0,        32'h0,        0,  0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,  32'h0,        32'h0,        32'h0,        0,  0, 1, 0, 0));

        foreach (vq[i]) begin
            @(negedge Clk);
            Rst = vq[i].rst; in_valid = vq[i].valid; in_le = vq[i].le; in_dbl = vq[i].dbl;
            in_rd = vq[i].rd; in_data = vq[i].data; in_data_hi = vq[i].hi;
            @(posedge Clk);
            #1;
            chk($sformatf("v%0d PW", i),       PW,                vq[i].e_pw);
            chk($sformatf("v%0d RW", i),       {27'b0, RW},       {27'b0, vq[i].e_rw});
            chk($sformatf("v%0d LE", i),       {31'b0, LE},       {31'b0, vq[i].e_le});
            chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, {31'b0, vq[i].e_rdy});
            chk($sformatf("v%0d busy", i),     {31'b0, busy},     {31'b0, vq[i].e_busy});
            chk($sformatf("v%0d wr_count", i), {16'b0, wr_count}, {16'b0, vq[i].e_cnt});
        end

        @(negedge Clk);
        chk("rf r0",  rf[0],  32'h0);
        chk("rf r1",  rf[1],  32'hABCD0001);
        chk("rf r2",  rf[2],  32'hA2);
        chk("rf r3",  rf[3],  32'hA3);
        chk("rf r4",  rf[4],  32'hA4);
        chk("rf r5",  rf[5],  32'h14);
        chk("rf r6",  rf[6],  32'h66);
        chk("rf r7",  rf[7],  32'h0);
        chk("rf r8",  rf[8],  32'h11111111);
        chk("rf r9",  rf[9],  32'h22222222);
        chk("rf r10", rf[10], 32'h0);
        chk("rf r11", rf[11], 32'h0);
        chk("rf r12", rf[12], 32'h0);
        chk("rf r13", rf[13], 32'h0);

        // Narrow counter: five committed writes saturate at 3.
        @(negedge Clk);
        s_rst = 1'b1;
        @(posedge Clk);
        #1;
        chk("sat reset count", {30'b0, s_cnt}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clk);
            s_rst = 1'b0; s_valid = 1'b1; s_le = 1'b1; s_dbl = 1'b0;
            s_rd = 5'(k); s_data = 32'(k);
            @(posedge Clk);
            #1;
            chk($sformatf("sat count w%0d", k), {30'b0, s_cnt}, (k < 3) ? 32'(k) : 32'd3);
        end
        @(negedge Clk);
        s_valid = 1'b0;
        @(posedge Clk);
        #1;
        chk("sat hold LE", {31'b0, s_le_o}, 32'd0);
        chk("sat hold count", {30'b0, s_cnt}, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
